// File: rtl/edge_event_arbiter.sv
// ============================================================================
// edge_event_arbiter
// ----------------------------------------------------------------------------
// Watches N_CH asynchronous level inputs. It synchronizes each one and detects
// rising and falling edges. Edges are queued as per-channel pending flags. One
// event at a time is presented on a valid/ready output port. A round-robin
// pointer chooses which channel is presented next.
//
// Each channel keeps one rise flag and one fall flag. A second edge of the same
// kind that arrives before the first has been handed out is merged into the
// flag that is already set, and it raises that channel's sticky overflow bit.
// A rise followed by a fall (or the reverse) before hand-out is reported as a
// single event with both evt_rise and evt_fall set.
//
// Parameters
//   N_CH      number of monitored channels (2..16)
//   SYNC_STG  synchronizer flops ahead of the edge-compare flop (0..3)
//   CH_W      derived channel-index width, clog2(N_CH) (not overridable)
//
// Ports
//   clk        single clock, all logic on posedge
//   rst        synchronous, active-high reset
//   in         asynchronous level inputs, one bit per channel
//   level      synchronized level per channel (last delay-chain flop)
//   evt_valid  an event is presented
//   evt_ready  consumer accepts the presented event
//   evt_ch     channel index of the presented event
//   evt_rise   a rising edge is pending on evt_ch
//   evt_fall   a falling edge is pending on evt_ch
//   ovf        sticky per-channel overflow flags
//   ovf_clr    write-1-to-clear for ovf
// ============================================================================
module edge_event_arbiter #(
  parameter int  N_CH     = 4,
  parameter int  SYNC_STG = 1,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in,
  output logic [N_CH-1:0]   level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_rise,
  output logic              evt_fall,
  output logic [N_CH-1:0]   ovf,
  input  logic [N_CH-1:0]   ovf_clr
);

  // --------------------------------------------------------------------------
  // Delay chain: stage 0 samples the raw input. Stage SYNC_STG is the
  // edge-compare flop and drives the level output.
  // --------------------------------------------------------------------------
  logic [SYNC_STG:0][N_CH-1:0] chain_q, chain_d;

  always_comb begin
    chain_d[0] = in;
    for (int k = 1; k <= SYNC_STG; k++) begin
      chain_d[k] = chain_q[k-1];
    end
  end

  // Edge-compare taps. With no synchronizer stages, the single flop is
  // compared directly against the raw input.
  logic [N_CH-1:0] tap_old, tap_new;

  generate
    if (SYNC_STG == 0) begin : g_tap_direct
      assign tap_new = in;
      assign tap_old = chain_q[0];
    end else begin : g_tap_chain
      assign tap_new = chain_q[SYNC_STG-1];
      assign tap_old = chain_q[SYNC_STG];
    end
  endgenerate

  logic [N_CH-1:0] rise_det, fall_det;

  assign rise_det = ~tap_old &  tap_new;
  assign fall_det =  tap_old & ~tap_new;

  // --------------------------------------------------------------------------
  // Pending flags, overflow flags, and output register state
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] rise_pend_q, rise_pend_d;
  logic [N_CH-1:0] fall_pend_q, fall_pend_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            evt_valid_q, evt_valid_d;
  logic [CH_W-1:0] evt_ch_q, evt_ch_d;
  logic            evt_rise_q, evt_rise_d;
  logic            evt_fall_q, evt_fall_d;

  // --------------------------------------------------------------------------
  // Round-robin search: the first channel with any pending flag, scanning
  // ptr, ptr+1, ... and wrapping modulo N_CH.
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] pend_any;
  logic            found;
  logic [CH_W-1:0] win;
  logic [CH_W:0]   rr_idx;

  assign pend_any = rise_pend_q | fall_pend_q;

  // NOTE: every variable written in an always_comb gets a default at the top.
  // Without it, an unassigned path infers a latch.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    rr_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      // One extra bit holds ptr+k, so the wrap works for any N_CH,
      // including values that are not a power of two.
      rr_idx = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (rr_idx >= (CH_W+1)'(N_CH)) begin
        rr_idx = rr_idx - (CH_W+1)'(N_CH);
      end
      if (!found && pend_any[rr_idx[CH_W-1:0]]) begin
        found = 1'b1;
        win   = rr_idx[CH_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register load and pointer advance
  // --------------------------------------------------------------------------
  logic            load;
  logic [N_CH-1:0] take;

  // The output register loads when it is empty or when its event is accepted
  // this cycle. Loading on acceptance gives one event per cycle when events
  // are handed over back to back.
  assign load = !evt_valid_q || evt_ready;

  always_comb begin
    take        = '0;
    ptr_d       = ptr_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_rise_d  = evt_rise_q;
    evt_fall_d  = evt_fall_q;
    if (load) begin
      evt_valid_d = found;
      evt_rise_d  = 1'b0;
      evt_fall_d  = 1'b0;
      if (found) begin
        take[win]  = 1'b1;
        evt_ch_d   = win;
        evt_rise_d = rise_pend_q[win];
        evt_fall_d = fall_pend_q[win];
        ptr_d      = (win == CH_W'(N_CH - 1)) ? '0 : win + CH_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending and overflow update.
  //
  // A flag that is being copied into the output register this cycle (take)
  // counts as free. An edge arriving in that same cycle starts a fresh
  // pending flag and is not an overflow. An edge that finds its flag still
  // occupied merges into it and raises ovf. Raising ovf takes priority over
  // a same-cycle write-1-to-clear.
  // --------------------------------------------------------------------------
  always_comb begin
    rise_pend_d = (rise_pend_q & ~take) | rise_det;
    fall_pend_d = (fall_pend_q & ~take) | fall_det;
    ovf_d       = (ovf_q & ~ovf_clr)
                | (rise_det & rise_pend_q & ~take)
                | (fall_det & fall_pend_q & ~take);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      // The delay chain is cleared as well. An input held high through reset
      // therefore appears as a rising edge once reset is released.
      chain_q     <= '0;
      rise_pend_q <= '0;
      fall_pend_q <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_rise_q  <= 1'b0;
      evt_fall_q  <= 1'b0;
    end else begin
      chain_q     <= chain_d;
      rise_pend_q <= rise_pend_d;
      fall_pend_q <= fall_pend_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_rise_q  <= evt_rise_d;
      evt_fall_q  <= evt_fall_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign level     = chain_q[SYNC_STG];
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_rise  = evt_rise_q;
  assign evt_fall  = evt_fall_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// ============================================================================
// tb_edge_event_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for edge_event_arbiter. dut_s1 uses N_CH=4, SYNC_STG=1.
// dut_s0 uses N_CH=4, SYNC_STG=0.
//
// A vector table drives dut_s1 through reset, a simultaneous three-channel
// rise, and a single rise. Each row holds the inputs for one cycle and the
// state expected after the next clock edge. Hand-written sequences then cover
// stall and overflow, merged rise/fall, reset mid-handshake, and
// input-high-through-reset on the SYNC_STG=0 instance.
// ============================================================================
module tb_edge_event_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_s1 signals
  logic       rst1, ready1;
  logic [3:0] in1, clr1, level1, ovf1;
  logic       valid1, rise1, fall1;
  logic [1:0] ch1;

  // dut_s0 signals
  logic       rst0, ready0;
  logic [3:0] in0, clr0, level0, ovf0;
  logic       valid0, rise0, fall0;
  logic [1:0] ch0;

  edge_event_arbiter #(.N_CH(4), .SYNC_STG(1)) dut_s1 (
    .clk       (clk),
    .rst       (rst1),
    .in        (in1),
    .level     (level1),
    .evt_valid (valid1),
    .evt_ready (ready1),
    .evt_ch    (ch1),
    .evt_rise  (rise1),
    .evt_fall  (fall1),
    .ovf       (ovf1),
    .ovf_clr   (clr1)
  );

  edge_event_arbiter #(.N_CH(4), .SYNC_STG(0)) dut_s0 (
    .clk       (clk),
    .rst       (rst0),
    .in        (in0),
    .level     (level0),
    .evt_valid (valid0),
    .evt_ready (ready0),
    .evt_ch    (ch0),
    .evt_rise  (rise0),
    .evt_fall  (fall0),
    .ovf       (ovf0),
    .ovf_clr   (clr0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] in;
    logic       ready;
    logic [3:0] clr;
    logic       exp_valid;
    logic       chk_data;   // compare ch/rise/fall on this row
    logic [1:0] exp_ch;
    logic       exp_rise;
    logic       exp_fall;
    logic [3:0] exp_level;
    logic [3:0] exp_ovf;
    logic [1:0] exp_ptr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // dut_s0 is held in reset until its own sequence runs.
    rst0 = 1'b1; in0 = 4'b0000; ready0 = 1'b1; clr0 = 4'b0000;

    //            rst   in       rdy   clr      v     chk   ch     r     f     level    ovf      ptr
    vecs[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0};
    // in[0], in[1], in[3] rise together. Expect events ch 0, 1, 3; ptr ends at 0.
    vecs[1]  = '{1'b0, 4'b1011, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0};
    vecs[2]  = '{1'b0, 4'b1011, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1011, 4'b0000, 2'd0};
    vecs[3]  = '{1'b0, 4'b1011, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1011, 4'b0000, 2'd1};
    vecs[4]  = '{1'b0, 4'b1011, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b1011, 4'b0000, 2'd2};
    vecs[5]  = '{1'b0, 4'b1011, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 4'b1011, 4'b0000, 2'd0};
    vecs[6]  = '{1'b0, 4'b1011, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1011, 4'b0000, 2'd0};
    // in[2] steps 0->1. Detect in row 8, event visible after row 9, level[2] after 2 clocks.
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1011, 4'b0000, 2'd0};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd0};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'd3};
    vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd3};
    vecs[11] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd3};

    for (int i = 0; i < 12; i++) begin
      rst1 = vecs[i].rst; in1 = vecs[i].in; ready1 = vecs[i].ready; clr1 = vecs[i].clr;
      tick();
      check($sformatf("vec%0d valid", i), 32'(valid1), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d level", i), 32'(level1), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d ovf", i),   32'(ovf1),   32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d ptr", i),   32'(dut_s1.ptr_q), 32'(vecs[i].exp_ptr));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d ch", i),   32'(ch1),   32'(vecs[i].exp_ch));
        check($sformatf("vec%0d rise", i), 32'(rise1), 32'(vecs[i].exp_rise));
        check($sformatf("vec%0d fall", i), 32'(fall1), 32'(vecs[i].exp_fall));
      end
    end

    // ---- Stall: three rises on in[1] with ready low -> held event, ovf[1] ----
    rst1 = 1'b1; in1 = 4'b0000; ready1 = 1'b0; clr1 = 4'b0000;
    tick();
    rst1 = 1'b0;
    tick(); tick();
    check("stall idle valid", 32'(valid1), 32'd0);
    in1 = 4'b0010; tick();
    in1 = 4'b0000; tick();                 // first rise detected
    in1 = 4'b0010; tick();                 // event loaded, fall detected
    check("stall valid", 32'(valid1), 32'd1);
    check("stall ch",    32'(ch1),    32'd1);
    check("stall rise",  32'(rise1),  32'd1);
    check("stall fall",  32'(fall1),  32'd0);
    in1 = 4'b0000; tick();                 // second rise into an empty rise flag
    check("stall ovf early", 32'(ovf1), 32'd0);
    in1 = 4'b0010; tick();                 // second fall merges -> overflow
    check("stall ovf set", 32'(ovf1), 32'b0010);
    tick(); tick(); tick();                // third rise merges too
    check("stall hold valid", 32'(valid1), 32'd1);
    check("stall hold ch",    32'(ch1),    32'd1);
    check("stall hold rise",  32'(rise1),  32'd1);
    check("stall hold fall",  32'(fall1),  32'd0);
    clr1 = 4'b0010; tick(); clr1 = 4'b0000;
    check("ovf clear", 32'(ovf1), 32'd0);
    ready1 = 1'b1; tick();                 // merged rise+fall now handed out
    check("merged valid", 32'(valid1), 32'd1);
    check("merged ch",    32'(ch1),    32'd1);
    check("merged rise",  32'(rise1),  32'd1);
    check("merged fall",  32'(fall1),  32'd1);
    tick();
    check("drained valid", 32'(valid1), 32'd0);

    // ---- in[3] pulses 1 then 0 while the output is stalled on ch 0 ----
    ready1 = 1'b0;
    in1 = 4'b0011; tick(); tick();
    in1 = 4'b1011; tick();
    check("pulse stall ch",   32'(ch1),    32'd0);
    check("pulse stall rise", 32'(rise1),  32'd1);
    in1 = 4'b0011; tick(); tick(); tick();
    check("pulse hold valid", 32'(valid1), 32'd1);
    check("pulse hold ch",    32'(ch1),    32'd0);
    check("pulse hold fall",  32'(fall1),  32'd0);
    check("pulse no ovf",     32'(ovf1),   32'd0);
    ready1 = 1'b1; tick();
    check("pulse valid", 32'(valid1), 32'd1);
    check("pulse ch",    32'(ch1),    32'd3);
    check("pulse rise",  32'(rise1),  32'd1);
    check("pulse fall",  32'(fall1),  32'd1);
    tick();
    check("pulse drained", 32'(valid1), 32'd0);
    check("pulse ovf",     32'(ovf1),   32'd0);

    // ---- Reset mid-handshake with two channels still pending ----
    in1 = 4'b0111; repeat (4) tick();      // ch2 rise goes out, output empties
    check("pre-rst idle", 32'(valid1), 32'd0);
    ready1 = 1'b0; in1 = 4'b0000;
    tick(); tick(); tick();                // falls on 0,1,2; ch0 loaded, 1 and 2 pending
    check("pre-rst valid", 32'(valid1), 32'd1);
    check("pre-rst ch",    32'(ch1),    32'd0);
    check("pre-rst fall",  32'(fall1),  32'd1);
    rst1 = 1'b1; tick();
    check("rst drops valid", 32'(valid1), 32'd0);
    rst1 = 1'b0; ready1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("post-rst quiet%0d", k), 32'(valid1), 32'd0);
    end

    // ---- SYNC_STG=0: in[0] held high through reset ----
    in0 = 4'b0001; tick(); tick();
    check("s0 rst valid", 32'(valid0), 32'd0);
    check("s0 rst level", 32'(level0), 32'd0);
    check("s0 rst ovf",   32'(ovf0),   32'd0);
    rst0 = 1'b0; tick();                   // detect cycle D -> pending at D+1
    check("s0 D+1 level", 32'(level0), 32'b0001);
    check("s0 D+1 valid", 32'(valid0), 32'd0);
    tick();
    check("s0 D+2 valid", 32'(valid0), 32'd1);
    check("s0 D+2 ch",    32'(ch0),    32'd0);
    check("s0 D+2 rise",  32'(rise0),  32'd1);
    check("s0 D+2 fall",  32'(fall0),  32'd0);
    tick();
    check("s0 single event", 32'(valid0), 32'd0);
    tick();
    check("s0 quiet", 32'(valid0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of monitored input channels (range 2..16).
REQ-002 SHALL have parameter SYNC_STG, default 1, meaning the number of synchronizer flops ahead of the edge-compare flop on each channel (range 0..3).
REQ-003 SHALL define CH_W = clog2(N_CH) as a derived width, not an overridable parameter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is posedge clk.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in, input, N_CH bits: asynchronous level inputs, one per channel.
REQ-007 SHALL have port level, output, N_CH bits: synchronized level per channel, taken from the last delay-chain flop.
REQ-008 SHALL have port evt_valid, output, 1 bit: an event is presented.
REQ-009 SHALL have port evt_ready, input, 1 bit: the consumer accepts the event.
REQ-010 SHALL have port evt_ch, output, CH_W bits: channel index of the presented event.
REQ-011 SHALL have port evt_rise, output, 1 bit: a rising edge is pending on evt_ch.
REQ-012 SHALL have port evt_fall, output, 1 bit: a falling edge is pending on evt_ch.
REQ-013 SHALL have port ovf, output, N_CH bits: sticky per-channel overflow flags.
REQ-014 SHALL have port ovf_clr, input, N_CH bits: write-1-to-clear for ovf.

Function
REQ-015 Each channel SHALL carry a delay chain of SYNC_STG+1 flops; with SYNC_STG=0 the chain is a single flop.
REQ-016 Detection SHALL compare the chain's last two taps: (older,newer)=01 means rise, 10 means fall; with SYNC_STG=0 the taps are (flop, in).
REQ-017 In detect cycle D, the channel's rise-pending or fall-pending flag SHALL be set, visible at D+1.
REQ-018 If a detected edge finds its pending flag already set and not being consumed that cycle, ovf[ch] SHALL set at D+1 and the pending flag stays 1 (events merge).
REQ-019 An edge detected in the same cycle that channel's flags are loaded into the output register SHALL set a fresh pending flag and SHALL NOT set ovf.
REQ-020 The output register SHALL be loadable when evt_valid=0 or when evt_valid&evt_ready=1.
REQ-021 On a load, the block SHALL select the first channel with any pending flag, searching round-robin from ptr, ptr+1, ... wrapping modulo N_CH.
REQ-022 On a load, the winner's evt_ch, evt_rise and evt_fall SHALL be copied to the output, its flags cleared, and ptr set to winner+1 mod N_CH.
REQ-023 If nothing is pending at load time, evt_valid SHALL be 0 next cycle and ptr is unchanged.
REQ-024 Latency from detect cycle D to evt_valid, with the output idle, SHALL be exactly 2 cycles (valid at D+2).
REQ-025 A channel carrying both a rise and a fall pending SHALL be reported as one event with evt_rise=evt_fall=1.
REQ-026 While evt_valid=1 and evt_ready=0, evt_ch, evt_rise and evt_fall SHALL hold stable.
REQ-027 On back-to-back handshakes with continuous pending events, the block SHALL sustain one event per cycle.
REQ-028 ovf_clr[i]=1 SHALL clear ovf[i] next cycle; a same-cycle overflow set on channel i SHALL win over the clear.

Reset
REQ-029 With rst=1 at posedge, the block SHALL clear all delay-chain flops, pending flags, ovf, ptr, evt_valid, evt_ch, evt_rise and evt_fall to 0.
REQ-030 rst mid-handshake SHALL drop evt_valid next cycle and discard all pending events without reporting them.
REQ-031 An input held high through reset SHALL be reported as a rising edge after reset release, a consequence of the 0-cleared chain.

Verification
REQ-032 Bench SHALL cover: N_CH=4, SYNC_STG=1, ready=1; in[2] steps 0->1 -> exactly one event with ch=2, rise=1, fall=0, 2 cycles after detect; level[2]=1 after 2 clocks.
REQ-033 Bench SHALL cover: in[0], in[1], in[3] rise in the same cycle, ready=1, ptr=0 -> events in order ch 0, 1, 3 on consecutive cycles; ptr ends at 0.
REQ-034 Bench SHALL cover: ready=0 while 3 rises occur on in[1] -> one event with ch=1, rise=1 held stable; ovf[1]=1; ovf_clr[1] pulse -> ovf[1]=0.
REQ-035 Bench SHALL cover: in[3] pulses 1 then 0 while the output is stalled -> one event with ch=3, rise=1, fall=1; no ovf.
REQ-036 Bench SHALL cover: SYNC_STG=0 with in[0] held 1 through reset -> after release, one rise event on ch 0 at D+2.
REQ-037 Bench SHALL cover: rst asserted while evt_valid=1 with 2 channels pending -> evt_valid=0 the next cycle and no further events appear with in stable.
